execute_cc_mreg: RTL and testbench

- Execute-stage back half of the pipelined Y86-64 core; sits directly downstream of the 64-bit ALU and consumes its valE.
- Derives ZF/SF/OF from the ALU operands and result, holds the architectural condition-code register, and evaluates Cnd for jXX/cmovXX.
- Latches the execute results into the E/M pipeline register, with stall and bubble control from the pipeline controller.

---
 rtl/y86_pkg.sv | 42 ++++
 rtl/cond_eval.sv | 31 +++
 rtl/execute_cc_mreg.sv | 128 ++++++++++++
 tb/tb_execute_cc_mreg.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, condition functions, status codes,
// register sentinel, ALU functions and condition-code bit positions.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

endpackage

// File: rtl/cond_eval.sv
// Evaluates a jXX/cmovXX condition from a {ZF,SF,OF} snapshot.
// Purely combinational so it can be shared with the branch-predict checker.
module cond_eval
    import y86_pkg::*;
(
    input  logic [2:0] cc,
    input  logic [3:0] ifun,
    output logic       cnd
);

    logic w_zf;
    logic w_lt;

    assign w_zf = cc[CC_ZF];
    assign w_lt = cc[CC_SF] ^ cc[CC_OF];

    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = w_lt | w_zf;
            C_L:     cnd = w_lt;
            C_E:     cnd = w_zf;
            C_NE:    cnd = ~w_zf;
            C_GE:    cnd = ~w_lt;
            C_G:     cnd = ~w_lt & ~w_zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_cc_mreg.sv
// Execute-stage back half: flag derivation, condition-code register, Cnd
// evaluation and the E/M pipeline register with stall/bubble control.
module execute_cc_mreg
    import y86_pkg::*;
#(
    parameter int W      = 64,
    parameter int STAT_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [STAT_W-1:0] E_stat,
    input  logic [3:0]        E_icode,
    input  logic [3:0]        E_ifun,
    input  logic [W-1:0]      E_valA,
    input  logic [3:0]        E_dstE,
    input  logic [3:0]        E_dstM,
    input  logic [1:0]        alu_fun,
    input  logic [W-1:0]      alu_a,
    input  logic [W-1:0]      alu_b,
    input  logic [W-1:0]      e_valE,
    input  logic [STAT_W-1:0] m_stat,
    input  logic [STAT_W-1:0] W_stat,
    input  logic              M_stall,
    input  logic              M_bubble,
    output logic              e_Cnd,
    output logic [3:0]        e_dstE,
    output logic [2:0]        cc_q,
    output logic [STAT_W-1:0] M_stat,
    output logic [3:0]        M_icode,
    output logic              M_Cnd,
    output logic [W-1:0]      M_valE,
    output logic [W-1:0]      M_valA,
    output logic [3:0]        M_dstE,
    output logic [3:0]        M_dstM
);

    localparam logic [STAT_W-1:0] STAT_AOK = STAT_W'(SAOK);
    localparam logic [STAT_W-1:0] STAT_HLT = STAT_W'(SHLT);
    localparam logic [STAT_W-1:0] STAT_ADR = STAT_W'(SADR);
    localparam logic [STAT_W-1:0] STAT_INS = STAT_W'(SINS);

    logic              w_of;
    logic [2:0]        w_flags;
    logic              w_m_exc;
    logic              w_w_exc;
    logic              w_set_cc;
    logic [2:0]        r_cc;
    logic [STAT_W-1:0] r_stat;
    logic [3:0]        r_icode;
    logic              r_cnd;
    logic [W-1:0]      r_valE;
    logic [W-1:0]      r_valA;
    logic [3:0]        r_dstE;
    logic [3:0]        r_dstM;

    always_comb begin
        w_of = 1'b0;
        case (alu_fun)
            ALU_ADD: w_of = (alu_a[W-1] == alu_b[W-1]) && (e_valE[W-1] != alu_a[W-1]);
            ALU_SUB: w_of = (alu_a[W-1] != alu_b[W-1]) && (e_valE[W-1] != alu_a[W-1]);
            default: w_of = 1'b0;
        endcase
    end

    assign w_flags = {(e_valE == '0), e_valE[W-1], w_of};

    // An exception further down the pipe must not let a younger OPq alter the CCs.
    assign w_m_exc  = (m_stat == STAT_ADR) || (m_stat == STAT_INS) || (m_stat == STAT_HLT);
    assign w_w_exc  = (W_stat == STAT_ADR) || (W_stat == STAT_INS) || (W_stat == STAT_HLT);
    assign w_set_cc = (E_icode == IOPQ) && !w_m_exc && !w_w_exc && !M_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cc <= 3'b100;
        end else if (w_set_cc) begin
            r_cc <= w_flags;
        end
    end

    assign cc_q = r_cc;

    cond_eval u_cond_eval (
        .cc   (r_cc),
        .ifun (E_ifun),
        .cnd  (e_Cnd)
    );

    assign e_dstE = ((E_icode == IRRMOVQ) && !e_Cnd) ? RNONE : E_dstE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat  <= STAT_AOK;
            r_icode <= INOP;
            r_cnd   <= 1'b0;
            r_valE  <= '0;
            r_valA  <= '0;
            r_dstE  <= RNONE;
            r_dstM  <= RNONE;
        end else if (M_stall) begin
            r_stat  <= r_stat;
        end else if (M_bubble) begin
            r_stat  <= STAT_AOK;
            r_icode <= INOP;
            r_cnd   <= 1'b0;
            r_valE  <= '0;
            r_valA  <= '0;
            r_dstE  <= RNONE;
            r_dstM  <= RNONE;
        end else begin
            r_stat  <= E_stat;
            r_icode <= E_icode;
            r_cnd   <= e_Cnd;
            r_valE  <= e_valE;
            r_valA  <= E_valA;
            r_dstE  <= e_dstE;
            r_dstM  <= E_dstM;
        end
    end

    assign M_stat  = r_stat;
    assign M_icode = r_icode;
    assign M_Cnd   = r_cnd;
    assign M_valE  = r_valE;
    assign M_valA  = r_valA;
    assign M_dstE  = r_dstE;
    assign M_dstM  = r_dstM;

endmodule

// File: tb/tb_execute_cc_mreg.sv
// Scoreboard bench for execute_cc_mreg: directed scenarios plus random traffic,
// checked against an arithmetic reference model of flags, conditions and E/M.
module tb_execute_cc_mreg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  E_stat;
    logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
    logic [63:0] E_valA, alu_a, alu_b, e_valE;
    logic [1:0]  alu_fun;
    logic [2:0]  m_stat, W_stat;
    logic        M_stall, M_bubble;
    logic        e_Cnd;
    logic [3:0]  e_dstE;
    logic [2:0]  cc_q;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE, M_valA;
    logic [3:0]  M_dstE, M_dstM;

    execute_cc_mreg #(.W(64), .STAT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valA(E_valA), .E_dstE(E_dstE), .E_dstM(E_dstM), .alu_fun(alu_fun),
        .alu_a(alu_a), .alu_b(alu_b), .e_valE(e_valE), .m_stat(m_stat), .W_stat(W_stat),
        .M_stall(M_stall), .M_bubble(M_bubble), .e_Cnd(e_Cnd), .e_dstE(e_dstE),
        .cc_q(cc_q), .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [2:0]  cc;
    } exp_t;

    int   tests = 0;
    int   fails = 0;
    exp_t q[$];

    // Reference state: architectural flags and the E/M register contents.
    logic  mz, ms, mo;
    exp_t  mreg;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t bubble_val();
        exp_t b;
        b = '0;
        b.stat = 3'd1; b.icode = 4'h1; b.cnd = 1'b0;
        b.dstE = 4'hF; b.dstM = 4'hF;
        return b;
    endfunction

    function automatic logic [63:0] alu(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
        case (f)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd2: return a & b;
            default: return a ^ b;
        endcase
    endfunction

    // Overflow = the exact signed result does not survive truncation to 64 bits.
    function automatic logic ovf(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
        logic signed [65:0] sa, sb, exact, trunc;
        sa = {{2{a[63]}}, a};
        sb = {{2{b[63]}}, b};
        if (f == 2'd0)      exact = sa + sb;
        else if (f == 2'd1) exact = sa - sb;
        else return 1'b0;
        trunc = {{2{exact[63]}}, exact[63:0]};
        return exact != trunc;
    endfunction

    function automatic logic cond_model(input logic [3:0] ifun);
        logic less;
        less = (ms != mo);
        case (ifun)
            4'd0: return 1'b1;
            4'd1: return less || mz;
            4'd2: return less;
            4'd3: return mz;
            4'd4: return !mz;
            4'd5: return !less;
            4'd6: return !less && !mz;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_exc(input logic [2:0] s);
        return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
    endfunction

    task automatic model_reset();
        mz = 1'b1; ms = 1'b0; mo = 1'b0;
        mreg = bubble_val();
        mreg.cc = 3'b100;
    endtask

    task automatic cycle(input logic [3:0] icode, input logic [3:0] ifun, input logic [1:0] fun,
                         input logic [63:0] a, input logic [63:0] b, input logic [2:0] es,
                         input logic [2:0] ms_in, input logic [2:0] ws, input logic [3:0] de,
                         input logic [3:0] dm, input logic [63:0] va, input logic st,
                         input logic bu);
        logic [63:0] v;
        logic        c;
        logic [3:0]  de_exp;
        @(negedge clk);
        v = alu(fun, a, b);
        E_icode = icode; E_ifun = ifun; alu_fun = fun; alu_a = a; alu_b = b; e_valE = v;
        E_stat = es; m_stat = ms_in; W_stat = ws; E_dstE = de; E_dstM = dm; E_valA = va;
        M_stall = st; M_bubble = bu;
        #1;
        c = cond_model(ifun);
        de_exp = (icode == 4'h2 && !c) ? 4'hF : de;
        chk("e_Cnd", {63'd0, e_Cnd}, {63'd0, c});
        chk("e_dstE", {60'd0, e_dstE}, {60'd0, de_exp});
        if (!st) begin
            if (bu) mreg = bubble_val();
            else begin
                mreg.stat = es; mreg.icode = icode; mreg.cnd = c; mreg.valE = v;
                mreg.valA = va; mreg.dstE = de_exp; mreg.dstM = dm;
            end
        end
        if (icode == 4'h6 && !is_exc(ms_in) && !is_exc(ws) && !st) begin
            mz = (v == 64'd0);
            ms = $signed(v) < 0;
            mo = ovf(fun, a, b);
        end
        mreg.cc = {mz, ms, mo};
        q.push_back(mreg);
    endtask

    // Simple pipeline op with everything healthy.
    task automatic op(input logic [3:0] icode, input logic [3:0] ifun, input logic [1:0] fun,
                      input logic [63:0] a, input logic [63:0] b, input logic [3:0] de);
        cycle(icode, ifun, fun, a, b, 3'd1, 3'd1, 3'd1, de, 4'hF, 64'h0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("cc_q",    {61'd0, cc_q},    {61'd0, e.cc});
                chk("M_stat",  {61'd0, M_stat},  {61'd0, e.stat});
                chk("M_icode", {60'd0, M_icode}, {60'd0, e.icode});
                chk("M_Cnd",   {63'd0, M_Cnd},   {63'd0, e.cnd});
                chk("M_valE",  M_valE, e.valE);
                chk("M_valA",  M_valA, e.valA);
                chk("M_dstE",  {60'd0, M_dstE},  {60'd0, e.dstE});
                chk("M_dstM",  {60'd0, M_dstM},  {60'd0, e.dstM});
            end
        end
    end

    initial begin : stim
        logic [63:0] a, b;
        logic [3:0]  ic;
        int          wait_cyc;
        rst_n = 1'b0;
        E_stat = 3'd1; E_icode = 4'h1; E_ifun = 4'h0; E_valA = '0; E_dstE = 4'hF; E_dstM = 4'hF;
        alu_fun = 2'd0; alu_a = '0; alu_b = '0; e_valE = '0;
        m_stat = 3'd1; W_stat = 3'd1; M_stall = 1'b0; M_bubble = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst cc_q", {61'd0, cc_q}, 64'd4);
        chk("rst M_icode", {60'd0, M_icode}, 64'd1);
        chk("rst M_dstE", {60'd0, M_dstE}, 64'hF);
        chk("rst M_stat", {61'd0, M_stat}, 64'd1);
        rst_n = 1'b1;

        op(4'h7, 4'd3, 2'd0, 64'd0, 64'd0, 4'hF);
        chk("je after reset", {63'd0, e_Cnd}, 64'd1);

        op(4'h6, 4'd1, 2'd1, 64'h8000000000000000, 64'h4000000000000000, 4'h2);
        op(4'h7, 4'd2, 2'd0, 64'd0, 64'd0, 4'hF);
        chk("sub ovf cc", {61'd0, cc_q}, 64'd1);
        chk("jl after ovf", {63'd0, e_Cnd}, 64'd1);

        op(4'h6, 4'd0, 2'd0, 64'h8000000000000000, 64'h8000000000000000, 4'h2);
        op(4'h2, 4'd4, 2'd0, 64'd0, 64'd0, 4'h3);
        chk("add cc", {61'd0, cc_q}, 64'd5);
        chk("cmovne dstE", {60'd0, e_dstE}, 64'hF);

        cycle(4'h6, 4'd3, 2'd3, '1, '1, 3'd1, 3'd3, 3'd1, 4'h2, 4'hF, 64'h0, 1'b0, 1'b0);
        op(4'h1, 4'd0, 2'd0, 64'd0, 64'd0, 4'hF);
        chk("cc held on SADR", {61'd0, cc_q}, 64'd5);
        op(4'h6, 4'd3, 2'd3, '1, '1, 4'h2);
        op(4'h1, 4'd0, 2'd0, 64'd0, 64'd0, 4'hF);
        chk("xor cc", {61'd0, cc_q}, 64'd4);

        for (int i = 0; i < 2; i++)
            cycle(4'h6, 4'($urandom_range(0, 3)), 2'($urandom), {$urandom, $urandom},
                  {$urandom, $urandom}, 3'd1, 3'd1, 3'd1, 4'($urandom), 4'($urandom),
                  {$urandom, $urandom}, 1'b1, 1'b1);
        cycle(4'h6, 4'd0, 2'd0, 64'd7, 64'd9, 3'd1, 3'd1, 3'd1, 4'h1, 4'h2, 64'h55, 1'b0, 1'b1);

        // Async reset pulse with 0x3C sitting in M_valE.
        op(4'h6, 4'd0, 2'd0, 64'h3C, 64'h0, 4'h4);
        @(negedge clk);
        M_stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async M_valE", M_valE, 64'd0);
        chk("async cc_q", {61'd0, cc_q}, 64'd4);
        model_reset();
        q.push_back(mreg);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: ic = 4'h6;
                1: ic = 4'h2;
                2: ic = 4'h7;
                default: ic = 4'($urandom_range(0, 11));
            endcase
            case ($urandom_range(0, 3))
                0: begin a = 64'h8000000000000000 | {32'd0, $urandom}; b = {1'b0, 31'($urandom), $urandom}; end
                1: begin a = {$urandom, $urandom}; b = a; end
                default: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
            endcase
            cycle(ic, 4'($urandom_range(0, 7)), 2'($urandom), a, b,
                  3'($urandom_range(1, 4)),
                  ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 4)) : 3'd1,
                  ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 4)) : 3'd1,
                  4'($urandom), 4'($urandom), {$urandom, $urandom},
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 5) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        chk("scoreboard drained", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
